// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor, carry chain split into STAGES chunks.
// Valid/ready stream in and out; all stages stall together on back-pressure.
module pipelined_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int CW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    logic adv;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic             v_i;
        logic             c_i;
        logic [WIDTH-1:0] a_i;
        logic [WIDTH-1:0] b_i;
        logic [WIDTH-1:0] r_i;
        logic [CW:0]      add;
        logic [WIDTH-1:0] r_d;
        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] r_q;

        if (k == 0) begin : g_head
            assign v_i = in_valid;
            assign a_i = A;
            assign b_i = Sub ? ~B : B;
            assign c_i = Sub;
            assign r_i = '0;
        end else begin : g_link
            assign v_i = g_st[k-1].v_q;
            assign a_i = g_st[k-1].a_q;
            assign b_i = g_st[k-1].b_q;
            assign c_i = g_st[k-1].c_q;
            assign r_i = g_st[k-1].r_q;
        end

        assign add = {1'b0, a_i[k*CW +: CW]}
                   + {1'b0, b_i[k*CW +: CW]}
                   + {{CW{1'b0}}, c_i};

        always_comb begin
            r_d = r_i;
            r_d[k*CW +: CW] = add[CW-1:0];
        end

        // Data only loads for real beats so outputs hold across bubbles.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                a_q <= '0;
                b_q <= '0;
                r_q <= '0;
            end else if (adv) begin
                v_q <= v_i;
                if (v_i) begin
                    c_q <= add[CW];
                    a_q <= a_i;
                    b_q <= b_i;
                    r_q <= r_d;
                end
            end
        end
    end

    logic ovf_d;
    logic zero_d;
    logic ovf_q;
    logic zero_q;
    logic unused_ops;

    // Carry into the MSB is recovered from the MSB sum bit.
    assign ovf_d = g_st[L].a_i[WIDTH-1]
                 ^ g_st[L].b_i[WIDTH-1]
                 ^ g_st[L].add[CW-1]
                 ^ g_st[L].add[CW];
    assign zero_d     = ~|g_st[L].r_d;
    assign unused_ops = ^{g_st[L].a_q, g_st[L].b_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv && g_st[L].v_i) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = g_st[L].v_q;
    assign Sum       = g_st[L].r_q;
    assign Cout      = g_st[L].c_q;
    assign Ovf       = ovf_q;
    assign Zero      = zero_q;

endmodule
